// File: rtl/ads_readout.sv
// ADS serial ADC readout: one conversion per AFE_CLK rise, words streamed out with channel tags.
// Optional build macro ADS_TEST_PATTERN_EN replaces the captured word with {8'hA5, channel}.
module ads_readout #(
  parameter int unsigned CH_NUM     = 64,
  parameter int unsigned CH_W       = 6,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned T_SETTLE   = 30,
  parameter int unsigned T_CONV     = 4,
  parameter int unsigned T_BUSY_MAX = 40,
  parameter int unsigned SCLK_HALF  = 1
) (
  input  logic              CLK_100M,
  input  logic              CLK_RST_N,
  input  logic              ADS_INIT_OK,
  input  logic              SAMPLE_EN,
  input  logic              AFE_CLK,
  output logic              ADS_CONVST,
  input  logic              ADS_BUSY,
  output logic              ADS_CS_N,
  output logic              ADS_SCLK,
  input  logic              ADS_SDO,
  output logic [DATA_W-1:0] DOUT,
  output logic [CH_W-1:0]   DOUT_CH,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              FRAME_DONE,
  output logic              ERR_OVERRUN,
  output logic              ERR_TIMEOUT,
  output logic              ERR_DROP
);

  typedef enum logic [2:0] {
    StIdle, StArmed, StSettle, StConv, StWaitBusy, StShift, StStore
  } state_e;

  localparam logic [CH_W:0] CH_END  = CH_NUM[CH_W:0];
  localparam logic [CH_W:0] CH_LAST = CH_END - 1'b1;
  localparam logic [7:0] SETTLE_END = 8'(T_SETTLE - 1);
  localparam logic [7:0] CONV_END   = 8'(T_CONV - 1);
  localparam logic [7:0] BUSY_END   = 8'(T_BUSY_MAX - 1);
  localparam logic [7:0] HALF_END   = 8'(SCLK_HALF - 1);
  localparam logic [5:0] BIT_END    = 6'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [5:0]        bit_q, bit_d;
  logic [CH_W:0]     ch_q, ch_d;
  logic              sclk_q, sclk_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CH_W-1:0]   dout_ch_q, dout_ch_d;
  logic              valid_q, valid_d;
  logic              frame_done_q, frame_done_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_drop_q, err_drop_d;
  logic              se_q1, se_q2, afe_q1, afe_q2;
  logic              se_rise, afe_rise;
  logic [DATA_W-1:0] store_word;

  assign se_rise  = se_q1 & ~se_q2;
  assign afe_rise = afe_q1 & ~afe_q2;

`ifdef ADS_TEST_PATTERN_EN
  assign store_word = {8'hA5, 8'(ch_q[CH_W-1:0])};
`else
  assign store_word = data_q;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    ch_d          = ch_q;
    sclk_d        = sclk_q;
    data_d        = data_q;
    dout_d        = dout_q;
    dout_ch_d     = dout_ch_q;
    valid_d       = valid_q;
    frame_done_d  = 1'b0;
    err_overrun_d = err_overrun_q;
    err_timeout_d = err_timeout_q;
    err_drop_d    = err_drop_q;

    if (valid_q && DOUT_READY) begin
      valid_d = 1'b0;
    end

    // Losing ADC configuration aborts the transaction; a pending output word is kept.
    if (!ADS_INIT_OK && (state_q != StIdle)) begin
      state_d = StIdle;
      sclk_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (se_rise && ADS_INIT_OK) begin
            state_d       = StArmed;
            ch_d          = '0;
            err_overrun_d = 1'b0;
            err_timeout_d = 1'b0;
            err_drop_d    = 1'b0;
          end
        end
        StArmed: begin
          if (afe_rise) begin
            cnt_d   = '0;
            state_d = (ch_q == CH_END) ? StIdle : StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == SETTLE_END) begin
            cnt_d   = '0;
            state_d = StConv;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StConv: begin
          if (cnt_q == CONV_END) begin
            cnt_d   = '0;
            state_d = StWaitBusy;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StWaitBusy: begin
          if (!ADS_BUSY) begin
            cnt_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            state_d = StShift;
          end else if (cnt_q == BUSY_END) begin
            err_timeout_d = 1'b1;
            data_d        = '1;
            state_d       = StStore;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StShift: begin
          if (cnt_q == HALF_END) begin
            cnt_d = '0;
            if (sclk_q) begin
              // Sample on the falling edge of SCLK, MSB first.
              sclk_d = 1'b0;
              data_d = {data_q[DATA_W-2:0], ADS_SDO};
              if (bit_q == BIT_END) begin
                state_d = StStore;
              end else begin
                bit_d = bit_q + 6'd1;
              end
            end else begin
              sclk_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StStore: begin
          if (!valid_q || DOUT_READY) begin
            dout_d    = store_word;
            dout_ch_d = ch_q[CH_W-1:0];
            valid_d   = 1'b1;
          end else begin
            err_drop_d = 1'b1;
          end
          ch_d = ch_q + 1'b1;
          if (ch_q == CH_LAST) begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            state_d = StArmed;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (afe_rise && (state_q != StIdle) && (state_q != StArmed)) begin
      err_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
    if (!CLK_RST_N) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_q         <= '0;
      ch_q          <= '0;
      sclk_q        <= 1'b0;
      data_q        <= '0;
      dout_q        <= '0;
      dout_ch_q     <= '0;
      valid_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_drop_q    <= 1'b0;
      se_q1         <= 1'b0;
      se_q2         <= 1'b0;
      afe_q1        <= 1'b0;
      afe_q2        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      ch_q          <= ch_d;
      sclk_q        <= sclk_d;
      data_q        <= data_d;
      dout_q        <= dout_d;
      dout_ch_q     <= dout_ch_d;
      valid_q       <= valid_d;
      frame_done_q  <= frame_done_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
      err_drop_q    <= err_drop_d;
      se_q1         <= SAMPLE_EN;
      se_q2         <= se_q1;
      afe_q1        <= AFE_CLK;
      afe_q2        <= afe_q1;
    end
  end

  assign ADS_CONVST  = (state_q == StConv);
  assign ADS_CS_N    = (state_q != StShift);
  assign ADS_SCLK    = sclk_q;
  assign DOUT        = dout_q;
  assign DOUT_CH     = dout_ch_q;
  assign DOUT_VALID  = valid_q;
  assign FRAME_DONE  = frame_done_q;
  assign ERR_OVERRUN = err_overrun_q;
  assign ERR_TIMEOUT = err_timeout_q;
  assign ERR_DROP    = err_drop_q;

endmodule

// File: tb/tb_ads_readout.sv
// Scoreboard bench for ads_readout: behavioural ADC model, expected words queued per accepted
// AFE edge, monitor pops on each VALID&&READY handshake.
module tb_ads_readout;

  logic        CLK_100M = 1'b0;
  logic        CLK_RST_N;
  logic        ADS_INIT_OK, SAMPLE_EN, AFE_CLK, ADS_BUSY, ADS_SDO, DOUT_READY;
  logic        ADS_CONVST, ADS_CS_N, ADS_SCLK, DOUT_VALID, FRAME_DONE;
  logic        ERR_OVERRUN, ERR_TIMEOUT, ERR_DROP;
  logic [15:0] DOUT;
  logic [5:0]  DOUT_CH;

  ads_readout dut (
    .CLK_100M   (CLK_100M),
    .CLK_RST_N  (CLK_RST_N),
    .ADS_INIT_OK(ADS_INIT_OK),
    .SAMPLE_EN  (SAMPLE_EN),
    .AFE_CLK    (AFE_CLK),
    .ADS_CONVST (ADS_CONVST),
    .ADS_BUSY   (ADS_BUSY),
    .ADS_CS_N   (ADS_CS_N),
    .ADS_SCLK   (ADS_SCLK),
    .ADS_SDO    (ADS_SDO),
    .DOUT       (DOUT),
    .DOUT_CH    (DOUT_CH),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .FRAME_DONE (FRAME_DONE),
    .ERR_OVERRUN(ERR_OVERRUN),
    .ERR_TIMEOUT(ERR_TIMEOUT),
    .ERR_DROP   (ERR_DROP)
  );

  always #5 CLK_100M = ~CLK_100M;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [21:0] exp_q[$];
  int          exp_ch;
  bit          have_acc;
  time         last_acc;
  time         t_afe;
  bit          busy_stuck = 1'b0;
  bit          ready_rand = 1'b0;
  int          convst_total = 0;
  int          cs_low_total = 0;
  int          frame_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [15:0] exp_word(input int ch, input bit tmo);
`ifdef ADS_TEST_PATTERN_EN
    return {8'hA5, 8'(ch)};
`else
    return tmo ? 16'hFFFF : 16'h1234 + 16'(ch);
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_100M);
      #2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_convst"}, ADS_CONVST, 1'b0);
    check({tag, "_cs_n"}, ADS_CS_N, 1'b1);
    check({tag, "_sclk"}, ADS_SCLK, 1'b0);
    check({tag, "_dout"}, DOUT, 16'h0);
    check({tag, "_dout_ch"}, DOUT_CH, 6'h0);
    check({tag, "_valid"}, DOUT_VALID, 1'b0);
    check({tag, "_frame_done"}, FRAME_DONE, 1'b0);
    check({tag, "_errs"}, {ERR_OVERRUN, ERR_TIMEOUT, ERR_DROP}, 3'b000);
  endtask

  task automatic start_frame();
    SAMPLE_EN = 1'b1;
    tick(2);
    SAMPLE_EN = 1'b0;
    tick(2);
    exp_ch   = 0;
    have_acc = 1'b0;
  endtask

  // mode: 0 expect word, 1 expect drop, 2 expect timeout word, 3 edge expected to be ignored
  task automatic afe_pulse(input int period, input int mode);
    bit ok;
    ok = !have_acc || (($time - last_acc) >= 1070);
    if (mode != 3 && ok && exp_ch < 64) begin
      if (mode != 1) exp_q.push_back({6'(exp_ch), exp_word(exp_ch, mode == 2)});
      exp_ch++;
      last_acc = $time;
      have_acc = 1'b1;
    end
    t_afe   = $time;
    AFE_CLK = 1'b1;
    tick(period / 2);
    AFE_CLK = 1'b0;
    tick(period - period / 2);
  endtask

  task automatic abort_frame();
    ADS_INIT_OK = 1'b0;
    tick(3);
    check("abort_cs_n", ADS_CS_N, 1'b1);
    check("abort_convst", ADS_CONVST, 1'b0);
    check("abort_sclk", ADS_SCLK, 1'b0);
    ADS_INIT_OK = 1'b1;
    tick(2);
  endtask

  // Scoreboard monitor, sampling on the falling clock edge.
  task automatic monitor_loop();
    logic        pv, pr;
    logic [15:0] pd;
    logic [5:0]  pc;
    logic [21:0] e;
    pv = 1'b0; pr = 1'b0; pd = '0; pc = '0;
    forever begin
      @(negedge CLK_100M);
      if (!CLK_RST_N) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("hold_valid", DOUT_VALID, 1'b1);
        check("hold_data", {DOUT_CH, DOUT}, {pc, pd});
      end
      if (DOUT_VALID && DOUT_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got ch %0d data %h expected none", DOUT_CH, DOUT);
        end else begin
          e = exp_q.pop_front();
          check("dout_ch", DOUT_CH, e[21:16]);
          check("dout", DOUT, e[15:0]);
        end
      end
      if (FRAME_DONE) frame_done_cnt++;
      pv = DOUT_VALID; pr = DOUT_READY; pd = DOUT; pc = DOUT_CH;
    end
  endtask

  // Behavioural ADC: returns 16'h1234 + conversion index within the frame.
  task automatic adc_loop();
    int          busy_t, conv_idx, idx, lat;
    logic        prev_cv, prev_sclk, prev_se;
    logic [15:0] word;
    busy_t = 0; conv_idx = 0; idx = 0; prev_cv = 0; prev_sclk = 0; prev_se = 0; word = '0;
    forever begin
      @(negedge CLK_100M);
      if (!CLK_RST_N) begin
        ADS_BUSY = 1'b0; ADS_SDO = 1'b0; busy_t = 0; idx = 0; prev_cv = 0; prev_sclk = 0;
        continue;
      end
      if (SAMPLE_EN && !prev_se) conv_idx = 0;
      prev_se = SAMPLE_EN;
      if (ADS_CONVST && !prev_cv) begin
        word = 16'h1234 + 16'(conv_idx);
        conv_idx++;
        convst_total++;
        busy_t   = busy_stuck ? 60 : int'($urandom_range(8, 30));
        ADS_BUSY = 1'b1;
        lat = int'(($time - t_afe) / 10);
        n_checks++;
        if (lat < 31 || lat > 32) begin
          n_errors++;
          $display("FAIL convst_latency: got %0d cycles expected 31..32", lat);
        end
      end else if (busy_t > 0) begin
        busy_t--;
        if (busy_t == 0) ADS_BUSY = 1'b0;
      end
      prev_cv = ADS_CONVST;
      if (ADS_CS_N) idx = 0;
      else begin
        cs_low_total++;
        if (prev_sclk && !ADS_SCLK) idx++;
      end
      prev_sclk = ADS_SCLK;
      ADS_SDO   = (idx < 16) ? word[15-idx] : 1'b0;
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge CLK_100M);
      #2;
      if (ready_rand) DOUT_READY = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int cs_before, cv_before, waited;
    CLK_RST_N = 1'b0; ADS_INIT_OK = 1'b1; SAMPLE_EN = 1'b0; AFE_CLK = 1'b0;
    ADS_BUSY = 1'b0; ADS_SDO = 1'b0; DOUT_READY = 1'b1;
    exp_ch = 0; have_acc = 1'b0; last_acc = 0; t_afe = 0;
    fork
      monitor_loop();
      adc_loop();
      ready_loop();
      begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none
    #1;
    check_reset_outputs("reset");
    tick(3);
    CLK_RST_N = 1'b1;
    tick(3);

    // Full frame, random AFE period and random READY.
    start_frame();
    ready_rand = 1'b1;
    for (int i = 0; i < 64; i++) afe_pulse(int'($urandom_range(110, 160)), 0);
    ready_rand = 1'b0;
    DOUT_READY = 1'b1;
    tick(20);
    check("frame_done_count", frame_done_cnt, 1);
    check("frame_errs", {ERR_OVERRUN, ERR_TIMEOUT, ERR_DROP}, 3'b000);
    check("frame_queue_empty", exp_q.size(), 0);

    // Backpressure: ch0 held, ch1 dropped, ch2 delivered.
    DOUT_READY = 1'b0;
    start_frame();
    afe_pulse(130, 0);
    afe_pulse(130, 1);
    check("drop_flag", ERR_DROP, 1'b1);
    DOUT_READY = 1'b1;
    afe_pulse(130, 0);
    tick(10);
    check("bp_queue_empty", exp_q.size(), 0);
    abort_frame();
    cv_before = convst_total;
    afe_pulse(130, 3);
    check("no_convst_after_abort", convst_total, cv_before);

    // BUSY stuck on ch1.
    start_frame();
    check("errs_cleared_on_start", ERR_DROP, 1'b0);
    afe_pulse(130, 0);
    busy_stuck = 1'b1;
    cs_before  = cs_low_total;
    afe_pulse(130, 2);
    busy_stuck = 1'b0;
    check("timeout_no_shift", cs_low_total, cs_before);
    check("timeout_flag", ERR_TIMEOUT, 1'b1);
    afe_pulse(130, 0);
    tick(10);
    check("tmo_queue_empty", exp_q.size(), 0);
    abort_frame();

    // AFE period 60: every second edge lands mid-conversion.
    start_frame();
    for (int i = 0; i < 6; i++) afe_pulse(60, 0);
    tick(100);
    check("overrun_flag", ERR_OVERRUN, 1'b1);
    check("overrun_no_timeout", ERR_TIMEOUT, 1'b0);
    check("ovr_queue_empty", exp_q.size(), 0);
    abort_frame();

    // Reset in the middle of SHIFT.
    start_frame();
    t_afe   = $time;
    AFE_CLK = 1'b1;
    waited  = 0;
    while (ADS_CS_N && waited < 200) begin
      tick(1);
      waited++;
    end
    check("reach_shift", ADS_CS_N, 1'b0);
    tick(5);
    CLK_RST_N = 1'b0;
    #1;
    check_reset_outputs("rst_mid_shift");
    tick(3);
    CLK_RST_N = 1'b1;
    AFE_CLK   = 1'b0;
    tick(70);
    cv_before = convst_total;
    afe_pulse(130, 3);
    check("idle_after_reset", convst_total, cv_before);
    check("rst_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ads_readout.md
Name: ads_readout

Overview:
Downstream companion of the AFE timing controller. Once per rising edge of AFE_CLK it converts one AFE analog channel through the ADS serial ADC: settle, CONVST pulse, wait for BUSY to drop, then shift out 16 bits. Each word is delivered, tagged with its channel index, over a valid/ready stream to the frame buffer. It runs in the CLK_100M domain, and AFE_CLK is a registered output of that same domain.

Parameters:
CH_NUM, 64, channels captured per frame.
CH_W, 6, width of channel index (clog2 CH_NUM).
DATA_W, 16, ADC word width.
T_SETTLE, 30, cycles from AFE_CLK rise to CONVST assert (AFE output settling).
T_CONV, 4, CONVST high width in cycles.
T_BUSY_MAX, 40, BUSY timeout in cycles.
SCLK_HALF, 1, SCLK half period in cycles (1 gives 50 MHz).

Ports:
CLK_100M  in  1  system clock.
CLK_RST_N  in  1  asynchronous active-low reset.
ADS_INIT_OK  in  1  ADC configured; block stays in IDLE while low.
SAMPLE_EN  in  1  rising edge starts a new frame.
AFE_CLK  in  1  AFE shift clock; each rising edge presents the next channel.
ADS_CONVST  out  1  conversion start, high pulse.
ADS_BUSY  in  1  high while converting.
ADS_CS_N  out  1  serial chip select, active low.
ADS_SCLK  out  1  serial clock, idle low.
ADS_SDO  in  1  serial data, MSB first.
DOUT  out  DATA_W  captured sample.
DOUT_CH  out  CH_W  channel index of DOUT.
DOUT_VALID  out  1  DOUT/DOUT_CH valid.
DOUT_READY  in  1  consumer accepts when VALID&&READY.
FRAME_DONE  out  1  one-cycle pulse after channel CH_NUM-1 is stored.
ERR_OVERRUN  out  1  sticky: AFE_CLK rose while not in IDLE/ARMED.
ERR_TIMEOUT  out  1  sticky: BUSY still high after T_BUSY_MAX.
ERR_DROP  out  1  sticky: a word was dropped because the output was still occupied.

Behaviour:
- Reset (async, CLK_RST_N=0): state IDLE. ADS_CONVST=0, ADS_CS_N=1, ADS_SCLK=0, DOUT=0, DOUT_CH=0, DOUT_VALID=0, FRAME_DONE=0, all ERR_*=0. Channel counter=0. Edge-detect registers for SAMPLE_EN and AFE_CLK=0.
- Edge detect: registered copies of SAMPLE_EN and AFE_CLK. A rise is cur=1 && reg=0, one cycle later than the pin.
- States: IDLE, ARMED, SETTLE, CONV, WAIT_BUSY, SHIFT, STORE.
- IDLE -> ARMED on SAMPLE_EN rise && ADS_INIT_OK. Same cycle: channel counter=0 and ERR_* cleared.
- ARMED -> SETTLE on AFE_CLK rise. If channel counter==CH_NUM, rises are ignored and the state returns to IDLE.
- SETTLE: count T_SETTLE cycles -> CONV.
- CONV: ADS_CONVST=1 for exactly T_CONV cycles -> WAIT_BUSY.
- WAIT_BUSY: on the first cycle BUSY=0 -> SHIFT.
  - If BUSY is still 1 after T_BUSY_MAX cycles: set ERR_TIMEOUT, go to STORE with data 16'hFFFF.
- SHIFT:
  - ADS_CS_N=0.
  - SCLK toggles every SCLK_HALF cycles, starting low.
  - ADS_SDO is shifted in MSB first on the cycle SCLK goes 1->0.
  - After DATA_W falling edges: CS_N=1, SCLK=0 -> STORE.
- STORE (1 cycle):
  - If DOUT_VALID=0 or DOUT_READY=1 this cycle: load DOUT/DOUT_CH, set VALID.
  - Otherwise: drop the word and set ERR_DROP.
  - Channel counter increments either way.
  - If the counter was CH_NUM-1: pulse FRAME_DONE and go to IDLE; else go to ARMED.
- Output handshake:
  - VALID clears on VALID&&READY unless STORE reloads in the same cycle, in which case it stays 1 with the new data.
  - DOUT and DOUT_CH are stable while VALID&&!READY.
- AFE_CLK rise in SETTLE/CONV/WAIT_BUSY/SHIFT/STORE: set ERR_OVERRUN. The edge is not queued and the current conversion completes.
- SAMPLE_EN rise outside IDLE: ignored.
- ADS_INIT_OK falling in any state: abort next cycle to IDLE, CS_N=1, CONVST=0, SCLK=0. DOUT_VALID and its data are retained until accepted.
- Worst-case per-channel latency: 30+4+40+32+1 = 107 cycles, which is less than the 130-cycle AFE_CLK period.

Optional Feature:
ADS_TEST_PATTERN_EN.
- Defined: the ADC transaction (CONVST/CS_N/SCLK) runs unchanged, but STORE loads DOUT = {8'hA5, channel index zero-extended to 8 bits}, ignoring SDO and the timeout data.
- Undefined: DOUT is the shifted SDO word. No pattern logic is synthesised.

Test Plan:
- Reset mid-SHIFT (CLK_RST_N low 3 cycles) -> outputs at reset values within the cycle, CS_N=1, SCLK=0, state IDLE.
- Normal capture: INIT_OK=1, SAMPLE_EN rise, AFE_CLK 130-cycle period, BUSY high 20 cycles, ADC model returns 16'h1234+ch, READY=1.
  - CONVST rises 31-32 cycles after each AFE_CLK rise.
  - 64 words 1234..1273 on DOUT_CH 0..63.
  - FRAME_DONE pulses once; no ERR_*.
- Backpressure: READY=0 for 2 channel periods -> word ch0 held stable, ch1 dropped, ERR_DROP=1; READY=1 -> ch0 accepted, then ch2 delivered.
- BUSY stuck high -> ERR_TIMEOUT=1, DOUT=16'hFFFF on that channel, SHIFT skipped (CS_N stays 1).
- AFE_CLK period 60 cycles -> ERR_OVERRUN=1, every second edge ignored, sequence not corrupted.
- With ADS_TEST_PATTERN_EN, channel 5 -> DOUT=16'hA505; ADS_INIT_OK low during a frame -> IDLE, no further CONVST.
